// File: rtl/gpio_pkg.sv
// Shared register map constants and byte-lane helpers
// for the Wishbone GPIO/IRQ controller.
package gpio_pkg;

    localparam logic [4:0] REG_OUT    = 5'd0;
    localparam logic [4:0] REG_OEB    = 5'd1;
    localparam logic [4:0] REG_IN     = 5'd2;
    localparam logic [4:0] REG_IRQ_EN = 5'd3;
    localparam logic [4:0] REG_RISE   = 5'd4;
    localparam logic [4:0] REG_FALL   = 5'd5;
    localparam logic [4:0] REG_STATUS = 5'd6;

    localparam int REG_STRIDE  = 8;
    localparam int WINDOW_BITS = 8;

    // Replace only the bytes whose select bit is set.
    function automatic logic [31:0] sel_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  sel
    );
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                r[b*8 +: 8] = new_v[b*8 +: 8];
            end
        end
        return r;
    endfunction

    // Merge a 32-bit bus word into the LO or HI half of a 64-bit register.
    function automatic logic [63:0] merge64(
        input logic [63:0] old_v,
        input logic        hi,
        input logic [31:0] dat,
        input logic [3:0]  sel
    );
        logic [63:0] r;
        r = old_v;
        if (hi) begin
            r[63:32] = sel_merge(old_v[63:32], dat, sel);
        end else begin
            r[31:0] = sel_merge(old_v[31:0], dat, sel);
        end
        return r;
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Per-pin input synchroniser with one extra delay flop
// so that rising and falling edges can be detected.
module gpio_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    // Shift the pad value through the synchroniser, then delay once more.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~dly_q;
    assign fall_o  = ~level_o & dly_q;

endmodule

// File: rtl/caravel_wb_gpio_irq.sv
// Wishbone-slave GPIO controller: pad outputs/enables, synchronised
// inputs, and edge-triggered interrupts routed onto NUM_IRQ lines.
module caravel_wb_gpio_irq
    import gpio_pkg::*;
#(
    parameter int          NUM_PINS    = 38,
    parameter int          NUM_IRQ     = 3,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_dat_i,
    input  logic [31:0]         wbs_adr_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    input  logic [NUM_PINS-1:0] gpio_i,
    output logic [NUM_PINS-1:0] gpio_o,
    output logic [NUM_PINS-1:0] gpio_oeb_no,
    output logic [NUM_IRQ-1:0]  irq_o
);

    localparam logic [63:0] PIN_MASK =
        (NUM_PINS >= 64) ? {64{1'b1}} : ((64'd1 << NUM_PINS) - 64'd1);

    logic [63:0] out_q, out_d;
    logic [63:0] oeb_q, oeb_d;
    logic [63:0] ien_q, ien_d;
    logic [63:0] rise_q, rise_d;
    logic [63:0] fall_q, fall_d;
    logic [63:0] stat_q, stat_d;
    logic [NUM_IRQ-1:0] irq_q, irq_d;

    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        pend_we_q;
    logic [4:0]  pend_idx_q;
    logic        pend_hi_q;
    logic [3:0]  pend_sel_q;
    logic [31:0] pend_dat_q;

    logic [NUM_PINS-1:0] in_lvl, in_rise, in_fall;
    logic [63:0] in_vec, edge_vec, clr_vec, rd_vec;
    logic [31:0] rd_word;
    logic [4:0]  cur_idx;
    logic        cur_hi;
    logic        req_sel, accept, wr_en;
    logic        unused_adr;

    for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
        gpio_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .d_i    (gpio_i[p]),
            .level_o(in_lvl[p]),
            .rise_o (in_rise[p]),
            .fall_o (in_fall[p])
        );
    end

    assign req_sel = wbs_cyc_i & wbs_stb_i &
        (wbs_adr_i[31:WINDOW_BITS] == BASE_ADDR[31:WINDOW_BITS]);
    // No new request is taken while the previous ack is on the bus.
    assign accept     = req_sel & ~ack_q;
    assign cur_idx    = wbs_adr_i[WINDOW_BITS-1:3];
    assign cur_hi     = wbs_adr_i[2];
    assign wr_en      = ack_q & pend_we_q;
    assign unused_adr = ^wbs_adr_i[1:0];

    // Widen the pin-level input and enabled edge vectors to the 64-bit map.
    always_comb begin
        in_vec   = '0;
        edge_vec = '0;
        in_vec[NUM_PINS-1:0]   = in_lvl;
        edge_vec[NUM_PINS-1:0] = (in_rise & rise_q[NUM_PINS-1:0]) |
                                 (in_fall & fall_q[NUM_PINS-1:0]);
    end

    // Read mux for the currently addressed register half.
    always_comb begin
        rd_vec = '0;
        unique case (cur_idx)
            REG_OUT:    rd_vec = out_q;
            REG_OEB:    rd_vec = oeb_q;
            REG_IN:     rd_vec = in_vec;
            REG_IRQ_EN: rd_vec = ien_q;
            REG_RISE:   rd_vec = rise_q;
            REG_FALL:   rd_vec = fall_q;
            REG_STATUS: rd_vec = stat_q;
            default:    rd_vec = '0;
        endcase
        rd_word = cur_hi ? rd_vec[63:32] : rd_vec[31:0];
        ack_d   = accept;
        dat_d   = (accept & ~wbs_we_i) ? rd_word : '0;
    end

    // Handshake: register ack and read data, hold the request for commit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            pend_we_q  <= 1'b0;
            pend_idx_q <= '0;
            pend_hi_q  <= 1'b0;
            pend_sel_q <= '0;
            pend_dat_q <= '0;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
            if (accept) begin
                pend_we_q  <= wbs_we_i;
                pend_idx_q <= cur_idx;
                pend_hi_q  <= cur_hi;
                pend_sel_q <= wbs_sel_i;
                pend_dat_q <= wbs_dat_i;
            end
        end
    end

    // Register writes commit at the end of the ack cycle; set beats clear.
    always_comb begin
        out_d   = out_q;
        oeb_d   = oeb_q;
        ien_d   = ien_q;
        rise_d  = rise_q;
        fall_d  = fall_q;
        clr_vec = '0;
        if (wr_en) begin
            unique case (pend_idx_q)
                REG_OUT: out_d = PIN_MASK &
                    merge64(out_q, pend_hi_q, pend_dat_q, pend_sel_q);
                REG_OEB: oeb_d = PIN_MASK &
                    merge64(oeb_q, pend_hi_q, pend_dat_q, pend_sel_q);
                REG_IRQ_EN: ien_d = PIN_MASK &
                    merge64(ien_q, pend_hi_q, pend_dat_q, pend_sel_q);
                REG_RISE: rise_d = PIN_MASK &
                    merge64(rise_q, pend_hi_q, pend_dat_q, pend_sel_q);
                REG_FALL: fall_d = PIN_MASK &
                    merge64(fall_q, pend_hi_q, pend_dat_q, pend_sel_q);
                REG_STATUS: clr_vec = PIN_MASK &
                    merge64(64'd0, pend_hi_q, pend_dat_q, pend_sel_q);
                default: ;
            endcase
        end
        stat_d = (stat_q & ~clr_vec) | edge_vec;
    end

    // Route enabled status bits onto lines by pin index modulo NUM_IRQ.
    always_comb begin
        irq_d = '0;
        for (int p = 0; p < NUM_PINS; p++) begin
            if (stat_q[p] & ien_q[p]) begin
                irq_d[p % NUM_IRQ] = 1'b1;
            end
        end
    end

    // Register file and interrupt output state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q  <= '0;
            oeb_q  <= PIN_MASK;
            ien_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            stat_q <= '0;
            irq_q  <= '0;
        end else begin
            out_q  <= out_d;
            oeb_q  <= oeb_d;
            ien_q  <= ien_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            stat_q <= stat_d;
            irq_q  <= irq_d;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign gpio_o      = out_q[NUM_PINS-1:0];
    assign gpio_oeb_no = oeb_q[NUM_PINS-1:0];
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_caravel_wb_gpio_irq.sv
// Randomised and directed bench for caravel_wb_gpio_irq with
// a behavioural reference model checked on every cycle.
module tb_caravel_wb_gpio_irq;

    localparam int          NP   = 38;
    localparam int          NI   = 3;
    localparam int          SS   = 2;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [63:0] PM   = (64'd1 << NP) - 64'd1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]    sel = '0;
    logic [31:0]   wdat = '0, adr = '0;
    logic          ack;
    logic [31:0]   rdat;
    logic [NP-1:0] gin = '0;
    logic [NP-1:0] gout, goeb;
    logic [NI-1:0] irq;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    caravel_wb_gpio_irq #(
        .NUM_PINS(NP), .NUM_IRQ(NI), .BASE_ADDR(BASE), .SYNC_STAGES(SS)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_dat_i(wdat), .wbs_adr_i(adr),
        .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .gpio_i(gin), .gpio_o(gout), .gpio_oeb_no(goeb), .irq_o(irq)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0]   m_reg [8];
    logic [63:0]   h     [8];
    logic          m_ack;
    logic [31:0]   m_dat;
    logic [NI-1:0] m_irq;
    logic          p_we;
    logic [31:0]   p_adr, p_dat;
    logic [3:0]    p_sel;

    function automatic logic [31:0] bytemask(input logic [3:0] s);
        logic [31:0] m;
        m = 0;
        for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
        return m;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic [63:0]   in_o, ind_o, setv, clrv, val, wm, d64;
        logic [NI-1:0] irqn;
        logic          accv;
        int            ix;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_reg[i] = 0;
                h[i]     = 0;
            end
            m_reg[1] = PM;
            m_ack = 0; m_dat = 0; m_irq = 0;
            p_we = 0; p_adr = 0; p_dat = 0; p_sel = 0;
        end else begin
            in_o  = h[SS-1];
            ind_o = h[SS];
            setv  = ((in_o & ~ind_o & m_reg[4]) |
                     (~in_o & ind_o & m_reg[5])) & PM;
            irqn = 0;
            for (int p = 0; p < NP; p++)
                if (m_reg[6][p] && m_reg[3][p]) irqn[p % NI] = 1'b1;
            accv = cyc && stb && (adr[31:8] == BASE[31:8]) && !m_ack;
            m_dat = 0;
            if (accv && !we) begin
                ix  = int'(adr[7:3]);
                val = (ix == 2) ? in_o : ((ix <= 6) ? m_reg[ix] : 64'd0);
                m_dat = adr[2] ? val[63:32] : val[31:0];
            end
            clrv = 0;
            if (m_ack && p_we) begin
                ix  = int'(p_adr[7:3]);
                wm  = p_adr[2] ? {bytemask(p_sel), 32'd0}
                               : {32'd0, bytemask(p_sel)};
                d64 = {p_dat, p_dat};
                if (ix == 6) clrv = d64 & wm & PM;
                else if (ix == 0 || ix == 1 || ix == 3 || ix == 4 || ix == 5)
                    m_reg[ix] = ((m_reg[ix] & ~wm) | (d64 & wm)) & PM;
            end
            m_reg[6] = (m_reg[6] & ~clrv) | setv;
            m_ack = accv;
            if (accv) begin
                p_we = we; p_adr = adr; p_dat = wdat; p_sel = sel;
            end
            for (int i = 7; i > 0; i--) h[i] = h[i-1];
            h[0] = 64'(gin);
            m_irq = irqn;
        end
    end

    // Compare every DUT output against the model once per cycle.
    always @(negedge clk) begin
        if (!rst) begin
            chk("ack", 64'(ack), 64'(m_ack));
            chk("rdata", 64'(rdat), 64'(m_dat));
            chk("gpio_o", 64'(gout), m_reg[0]);
            chk("gpio_oeb", 64'(goeb), m_reg[1]);
            chk("irq", 64'(irq), 64'(m_irq));
        end
    end

    // ---------------- bus tasks ----------------
    task automatic wb(input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] r, output logic ok);
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
        ok = 0; r = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack) begin
                ok = 1;
                r  = rdat;
                break;
            end
        end
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        logic [31:0] r;
        logic ok;
        wb(1'b1, a, d, s, r, ok);
        chk("wr_ack", 64'(ok), 64'd1);
    endtask

    task automatic rd(input string nm, input logic [31:0] a,
                      input logic [31:0] exp);
        logic [31:0] r;
        logic ok;
        wb(1'b0, a, 32'd0, 4'hF, r, ok);
        chk({nm, "_ack"}, 64'(ok), 64'd1);
        chk(nm, 64'(r), 64'(exp));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] r;
        logic        ok;
        int          cnt;
        logic [31:0] a;
        int          ix;

        #23 rst = 0;
        @(negedge clk);
        chk("rst_oeb", 64'(goeb), PM);
        chk("rst_out", 64'(gout), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);

        // Output and OEB writes with byte lanes
        wr(BASE + 32'h0, 32'hA5A5_A5A5, 4'b0011);
        wr(BASE + 32'h4, 32'h0000_003F, 4'hF);
        @(negedge clk);
        chk("out_pins", 64'(gout), 64'h3F_0000_A5A5);
        rd("out_hi", BASE + 32'h4, 32'h3F);
        wr(BASE + 32'h4, 32'hFFFF_FFFF, 4'hF);
        rd("out_hi_mask", BASE + 32'h4, 32'h3F);
        wr(BASE + 32'h8, 32'h0000_FFF0, 4'hF);
        @(negedge clk);
        chk("oeb_pins", 64'(goeb), 64'h3F_0000_FFF0);

        // Input synchroniser latency
        @(negedge clk);
        gin[5] = 1'b1;
        rd("in_early", BASE + 32'h10, 32'h0);
        rd("in_late", BASE + 32'h10, 32'h20);

        // Rising-edge interrupt on pin 4 -> line 1
        wr(BASE + 32'h20, 32'h10, 4'hF);
        wr(BASE + 32'h18, 32'h10, 4'hF);
        @(negedge clk);
        gin[4] = 1'b1;
        repeat (3) @(negedge clk);
        gin[4] = 1'b0;
        repeat (3) @(negedge clk);
        rd("status_set", BASE + 32'h30, 32'h10);
        chk("irq_line1", 64'(irq), 64'b010);
        wr(BASE + 32'h30, 32'h10, 4'hF);
        repeat (2) @(negedge clk);
        chk("irq_clear", 64'(irq), 64'd0);
        rd("status_clr", BASE + 32'h30, 32'h0);

        // Set and W1C land on the same edge
        @(negedge clk);
        gin[4] = 1'b1;
        wr(BASE + 32'h30, 32'h10, 4'hF);
        rd("set_wins", BASE + 32'h30, 32'h10);
        gin[4] = 1'b0;

        // Window decode
        rd("hole_0x80", BASE + 32'h80, 32'h0);
        wb(1'b0, BASE + 32'h100, 32'd0, 4'hF, r, ok);
        chk("oow_noack", 64'(ok), 64'd0);
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = BASE; sel = 4'hF;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack) cnt++;
        end
        cyc = 0; stb = 0;
        chk("held_acks", 64'(cnt), 64'd4);

        // Randomised traffic
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 1) == 1)
                gin = NP'({$urandom(), $urandom()});
            ix = $urandom_range(0, 8);
            if (ix == 8) a = BASE + 32'h80 + 32'($urandom_range(0, 15) * 4);
            else a = BASE + 32'(ix * 8) + 32'($urandom_range(0, 1) * 4);
            wb(1'($urandom_range(0, 1)), a, $urandom(),
               4'($urandom_range(0, 15)), r, ok);
            chk("rnd_ack", 64'(ok), 64'd1);
        end

        // Reset during an ack drops it and loses the write
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = BASE; wdat = 32'hFFFF_FFFF; sel = 4'hF;
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("mid_rst_ack", 64'(ack), 64'd0);
        chk("mid_rst_oeb", 64'(goeb), PM);
        chk("mid_rst_out", 64'(gout), 64'd0);
        chk("mid_rst_irq", 64'(irq), 64'd0);
        cyc = 0; stb = 0; we = 0;
        @(negedge clk);
        #1 rst = 0;
        rd("lost_write", BASE, 32'h0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
